// File: rtl/tt_um_accelshark_psg_period_meter.sv
// Measures the period and high time of a slow asynchronous input in clk cycles.
// Latency: period_valid rises SYNC_STAGES+1 clk edges after the sig_in rising edge that closes a period.
// Backpressure: none; results are a one-cycle strobe and must be captured while period_valid is high.
module tt_um_accelshark_psg_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // IDLE: waiting for a first edge; ARMED: first period open; RUN: steady measurement
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       hcnt, hcnt_nxt;
    logic [CNT_W-1:0]       hshadow, hshadow_nxt;
    logic [CNT_W-1:0]       period_nxt, high_nxt;
    logic                   pv_nxt, ns_nxt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Synchroniser and previous-level flop; runs regardless of ena so re-enable needs no flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    // Measurement state, counters and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            hshadow      <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hcnt         <= hcnt_nxt;
            hshadow      <= hshadow_nxt;
            period       <= period_nxt;
            high_time    <= high_nxt;
            period_valid <= pv_nxt;
            no_signal    <= ns_nxt;
        end
    end

    // Next state: a rise closes a period (except the very first), a saturated count times out
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hcnt_nxt    = hcnt;
        hshadow_nxt = hshadow;
        period_nxt  = period;
        high_nxt    = high_time;
        pv_nxt      = 1'b0;
        ns_nxt      = no_signal;
        if (!ena) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            hcnt_nxt    = '0;
            hshadow_nxt = '0;
            ns_nxt      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt  = '0;
                    hcnt_nxt = '0;
                    if (rise) begin
                        state_nxt   = ARMED;
                        cnt_nxt     = ONE;
                        hcnt_nxt    = ONE;
                        hshadow_nxt = '0;
                    end
                end
                default: begin
                    // ARMED and RUN behave alike; RUN only records that a result exists
                    if (rise) begin
                        period_nxt  = cnt;
                        high_nxt    = hshadow;
                        pv_nxt      = 1'b1;
                        cnt_nxt     = ONE;
                        hcnt_nxt    = ONE;
                        hshadow_nxt = '0;
                        state_nxt   = RUN;
                        ns_nxt      = 1'b0;
                    end else if (cnt == MAX) begin
                        // No rise within the counter range: drop back and wait for a fresh edge
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        hcnt_nxt  = '0;
                        ns_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ONE;
                        if (s && (hcnt != MAX)) begin
                            hcnt_nxt = hcnt + ONE;
                        end
                        if (fall) begin
                            hshadow_nxt = hcnt;
                        end
                    end
                end
            endcase
        end
    end

endmodule
